softmax_sequencer: RTL and testbench
====================================

SOFTMAX_SEQUENCER -- requirements
Module: softmax_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM address width.
REQ-002 SHALL have parameters EXP_LAT=4, ACC_LAT=3, RECI_LAT=8 and MUL_LAT=2, meaning pipeline latencies in cycles, each 1..15.
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1, the synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a request to run one softmax vector.
REQ-006 SHALL have port vec_len, input, ADDR_W+1, the element count, sampled with start.
REQ-007 SHALL have ports busy and done, output, 1 each: busy while running; done is a one-cycle completion pulse.
REQ-008 SHALL have ports ram1_en_b (output, 1) and ram1_addr (output, ADDR_W), the input-RAM read port.
REQ-009 SHALL have ports ram2_en_a, ram2_wr_en_a (output, 1 each) and ram2_addr_a (output, ADDR_W), the exponent write port.
REQ-010 SHALL have ports acc_clr and acc_en, output, 1 each: accumulator clear and enable.
REQ-011 SHALL have port reci_start, output, 1, a one-cycle reciprocal launch pulse.
REQ-012 SHALL have ports ram2_en_b (output, 1) and ram2_addr_b (output, ADDR_W), the exponent read port.
REQ-013 SHALL have ports ram3_enable_a, ram3_wr_en_a (output, 1 each) and ram3_addr_a (output, ADDR_W), the result write port.
REQ-014 SHALL have port phase, output, 3, the current state encoding.

Function
REQ-015 All outputs SHALL be registered; cycle n means the n-th rising edge after the edge that samples start.
REQ-016 The FSM SHALL have the states IDLE, EXPO, ACC_DRAIN, RECI, MULT, MULT_DRAIN and FIN.
REQ-017 In IDLE, when start=1 and vec_len!=0, the block SHALL latch N=min(vec_len, 2^ADDR_W), pulse acc_clr in cycle 0, and enter EXPO.
REQ-018 When start=1 with vec_len=0, or start arrives while busy=1, the block SHALL ignore start with no state change and no done.
REQ-019 EXPO SHALL read for cycles 1..N with ram1_en_b=1 and ram1_addr=k-1 in cycle k.
REQ-020 The block SHALL assert ram2_en_a, ram2_wr_en_a and acc_en in cycles 1+EXP_LAT..N+EXP_LAT, with ram2_addr_a equal to the delayed read address.
REQ-021 The delay SHALL be implemented as a valid/address shift pipeline and SHALL NOT be recomputed.
REQ-022 ACC_DRAIN SHALL wait ACC_LAT cycles after the last acc_en.
REQ-023 RECI SHALL pulse reci_start in its first cycle, then hold for RECI_LAT cycles in total.
REQ-024 MULT SHALL assert ram2_en_b with ram2_addr_b=0..N-1 over N cycles.
REQ-025 The block SHALL assert ram3_enable_a and ram3_wr_en_a MUL_LAT cycles after each read, with ram3_addr_a equal to the delayed address.
REQ-026 MULT_DRAIN SHALL wait until the last ram3 write has issued.
REQ-027 FIN SHALL assert done for exactly 1 cycle, after which the FSM returns to IDLE; start SHALL be accepted in the following cycle.
REQ-028 busy SHALL be 1 in every state except IDLE, and 0 in IDLE; no RAM or accumulator enable SHALL assert outside its own phase.
REQ-029 Address counters SHALL be ADDR_W wide; N=2^ADDR_W SHALL complete with the last address all-ones, with no wrap or early stop.
REQ-030 Latency and phase counters SHALL be 4 bits wide; the element counter SHALL be ADDR_W+1 bits wide.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE, clear all outputs, counters and delay pipelines to 0, and SHALL NOT assert done.
REQ-032 Reset during any phase SHALL abort the run; any in-flight delayed writes SHALL be discarded.

Structure
REQ-033 The state encoding and the default latency constants SHALL live in the shared package softmax_pkg.
REQ-034 One sub-module, delay_line (a parameterised valid+address shift register), SHALL be instantiated twice: once for the EXP_LAT path and once for the MUL_LAT path.

Verification
REQ-035 The bench SHALL cover: N=5, default latencies, start in cycle 0 -> ram1 reads in cycles 1-5 at addresses 0-4, ram2 writes and acc_en in cycles 5-9, reci_start in cycle 13, ram2_b reads in cycles 21-25, ram3 writes in cycles 23-27 at addresses 0-4, done in cycle 28, busy=0 in cycle 29.
REQ-036 The bench SHALL cover: vec_len=0 with start=1 -> busy stays 0, no enables, no done.
REQ-037 The bench SHALL cover: a second start in cycle 10 of an N=5 run -> ignored, exactly one done, in cycle 28.
REQ-038 The bench SHALL cover: rst=0 in cycle 7 of an N=5 run -> in cycle 8 all outputs are 0, phase=IDLE, and no ram2 write occurs for addresses 3-4.
REQ-039 The bench SHALL cover: vec_len=1024 with ADDR_W=10 -> 1024 ram3 writes, last at address 1023, done once.
REQ-040 The bench SHALL cover: back-to-back runs with N=3 and then N=2, the second start in the cycle after done -> both complete, with correct address sequences and acc_clr pulsed at each accepted start.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax sequencer: FSM state encoding and default latencies.
package softmax_pkg;

  localparam int unsigned ADDR_W_DEF   = 10;
  localparam int unsigned EXP_LAT_DEF  = 4;
  localparam int unsigned ACC_LAT_DEF  = 3;
  localparam int unsigned RECI_LAT_DEF = 8;
  localparam int unsigned MUL_LAT_DEF  = 2;

  // Latency/phase counters are 4 bits, enough for latencies of 1..15.
  localparam int unsigned LAT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EXPO       = 3'd1,
    S_ACC_DRAIN  = 3'd2,
    S_RECI       = 3'd3,
    S_MULT       = 3'd4,
    S_MULT_DRAIN = 3'd5,
    S_FIN        = 3'd6
  } state_e;

endpackage

// File: rtl/delay_line.sv
// Valid+address shift register: presents i_vld/i_addr LAT cycles later.
// Ports: clk, rst (sync active-low), i_vld/i_addr in, o_vld/o_addr out (registered).
// The address is zeroed when not valid so idle outputs stay at 0.
module delay_line #(
  parameter int unsigned LAT = 4,
  parameter int unsigned AW  = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [AW-1:0] i_addr,
  output logic          o_vld,
  output logic [AW-1:0] o_addr
);

  logic [LAT-1:0] r_vld;
  logic [AW-1:0]  r_addr [LAT];

  // Shift stage 0 -> LAT-1; reset flushes anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld <= '0;
      for (int i = 0; i < int'(LAT); i++) r_addr[i] <= '0;
    end else begin
      r_vld[0]  <= i_vld;
      r_addr[0] <= i_vld ? i_addr : '0;
      for (int i = 1; i < int'(LAT); i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_addr = r_addr[LAT-1];

endmodule

// File: rtl/softmax_sequencer.sv
// Softmax sequencer: drives RAM/accumulator/reciprocal/multiplier control for one vector.
// Ports: clk, rst (sync active-low); start + vec_len request a run; busy/done status;
// ram1 read port, ram2 write (a) and read (b) ports, acc_clr/acc_en, reci_start,
// ram3 write port, phase = current FSM state. All outputs come straight from registers.
module softmax_sequencer
  import softmax_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned EXP_LAT  = EXP_LAT_DEF,
  parameter int unsigned ACC_LAT  = ACC_LAT_DEF,
  parameter int unsigned RECI_LAT = RECI_LAT_DEF,
  parameter int unsigned MUL_LAT  = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   vec_len,
  output logic              busy,
  output logic              done,
  output logic              ram1_en_b,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram2_en_a,
  output logic              ram2_wr_en_a,
  output logic [ADDR_W-1:0] ram2_addr_a,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              reci_start,
  output logic              ram2_en_b,
  output logic [ADDR_W-1:0] ram2_addr_b,
  output logic              ram3_enable_a,
  output logic              ram3_wr_en_a,
  output logic [ADDR_W-1:0] ram3_addr_a,
  output logic [2:0]        phase
);

  localparam logic [ADDR_W:0]    MAX_N     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]    ONE_N     = (ADDR_W+1)'(1);
  localparam logic [LAT_W-1:0]   ACC_LAST  = LAT_W'(ACC_LAT - 1);
  localparam logic [LAT_W-1:0]   RECI_LAST = LAT_W'(RECI_LAT - 1);
  localparam logic [LAT_W-1:0]   MUL_LAST  = LAT_W'(MUL_LAT - 1);

  state_e            r_state, w_next;
  logic [ADDR_W:0]   r_n, r_cnt, r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LAT_W-1:0]  r_lat;

  logic w_accept, w_last_elem, w_acc_done;

  logic              r_busy, r_done, r_ram1_en, r_acc_clr, r_reci_start, r_ram2b_en;
  logic [ADDR_W-1:0] r_ram1_addr, r_ram2b_addr;
  logic              w_busy, w_done, w_ram1_en, w_acc_clr, w_reci_start, w_ram2b_en;
  logic [ADDR_W-1:0] w_ram1_addr, w_ram2b_addr;

  logic              w_exp_vld, w_mul_vld;
  logic [ADDR_W-1:0] w_exp_addr, w_mul_addr;

  assign w_accept    = start && (vec_len != '0);
  assign w_last_elem = (r_cnt == r_n - ONE_N);
  // True from the cycle of the last ram2 write/acc_en onward.
  assign w_acc_done  = (r_wcnt == r_n) || (w_exp_vld && (r_wcnt == r_n - ONE_N));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_accept) w_next = S_EXPO;
      S_EXPO:       if (w_last_elem) w_next = S_ACC_DRAIN;
      S_ACC_DRAIN:  if (w_acc_done && (r_lat == ACC_LAST)) w_next = S_RECI;
      S_RECI:       if (r_lat == RECI_LAST) w_next = S_MULT;
      S_MULT:       if (w_last_elem) w_next = S_MULT_DRAIN;
      S_MULT_DRAIN: if (r_lat == MUL_LAST) w_next = S_FIN;
      S_FIN:        w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Output decode (next values of the output registers).
  always_comb begin
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_acc_clr    = 1'b0;
    w_ram1_en    = 1'b0;
    w_ram1_addr  = '0;
    w_reci_start = 1'b0;
    w_ram2b_en   = 1'b0;
    w_ram2b_addr = '0;
    w_busy       = (w_next != S_IDLE);
    w_done       = (r_state == S_FIN);
    w_acc_clr    = (r_state == S_IDLE) && w_accept;
    if (r_state == S_EXPO) begin
      w_ram1_en   = 1'b1;
      w_ram1_addr = r_addr;
    end
    w_reci_start = (r_state == S_RECI) && (r_lat == '0);
    if (r_state == S_MULT) begin
      w_ram2b_en   = 1'b1;
      w_ram2b_addr = r_addr;
    end
  end

  // Output registers and element/address/latency counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_ram1_en    <= 1'b0;
      r_ram1_addr  <= '0;
      r_reci_start <= 1'b0;
      r_ram2b_en   <= 1'b0;
      r_ram2b_addr <= '0;
      r_n          <= '0;
      r_cnt        <= '0;
      r_wcnt       <= '0;
      r_addr       <= '0;
      r_lat        <= '0;
    end else begin
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_acc_clr    <= w_acc_clr;
      r_ram1_en    <= w_ram1_en;
      r_ram1_addr  <= w_ram1_addr;
      r_reci_start <= w_reci_start;
      r_ram2b_en   <= w_ram2b_en;
      r_ram2b_addr <= w_ram2b_addr;

      // Element count is clamped to the RAM depth.
      if ((r_state == S_IDLE) && w_accept)
        r_n <= (vec_len > MAX_N) ? MAX_N : vec_len;

      // Shared read counter for EXPO and MULT; the address may wrap to 0 on the last
      // element of a full-depth run, which is harmless since it is cleared here anyway.
      if ((r_state == S_EXPO) || (r_state == S_MULT)) begin
        if (w_last_elem) begin
          r_cnt  <= '0;
          r_addr <= '0;
        end else begin
          r_cnt  <= r_cnt + ONE_N;
          r_addr <= r_addr + ADDR_W'(1);
        end
      end else begin
        r_cnt  <= '0;
        r_addr <= '0;
      end

      // Count ram2 writes so the accumulator drain knows when the last one lands.
      if (r_state == S_IDLE) r_wcnt <= '0;
      else if (w_exp_vld)    r_wcnt <= r_wcnt + ONE_N;

      if (w_next != r_state) begin
        r_lat <= '0;
      end else begin
        case (r_state)
          S_ACC_DRAIN:         r_lat <= w_acc_done ? r_lat + LAT_W'(1) : '0;
          S_RECI, S_MULT_DRAIN: r_lat <= r_lat + LAT_W'(1);
          default:             r_lat <= '0;
        endcase
      end
    end
  end

  delay_line #(.LAT(EXP_LAT), .AW(ADDR_W)) u_exp_dly (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_ram1_en),
    .i_addr (r_ram1_addr),
    .o_vld  (w_exp_vld),
    .o_addr (w_exp_addr)
  );

  delay_line #(.LAT(MUL_LAT), .AW(ADDR_W)) u_mul_dly (
    .clk    (clk),
    .rst    (rst),
    .i_vld  (r_ram2b_en),
    .i_addr (r_ram2b_addr),
    .o_vld  (w_mul_vld),
    .o_addr (w_mul_addr)
  );

  assign busy          = r_busy;
  assign done          = r_done;
  assign acc_clr       = r_acc_clr;
  assign ram1_en_b     = r_ram1_en;
  assign ram1_addr     = r_ram1_addr;
  assign reci_start    = r_reci_start;
  assign ram2_en_b     = r_ram2b_en;
  assign ram2_addr_b   = r_ram2b_addr;
  assign ram2_en_a     = w_exp_vld;
  assign ram2_wr_en_a  = w_exp_vld;
  assign acc_en        = w_exp_vld;
  assign ram2_addr_a   = w_exp_addr;
  assign ram3_enable_a = w_mul_vld;
  assign ram3_wr_en_a  = w_mul_vld;
  assign ram3_addr_a   = w_mul_addr;
  assign phase         = r_state;

endmodule

// File: tb/tb_softmax_sequencer.sv
// Bench for softmax_sequencer: directed scenarios plus random start/reset traffic,
// every cycle compared against a timeline model of one softmax run.
module tb_softmax_sequencer;
  import softmax_pkg::*;

  localparam int AW = 10, E = 4, A = 3, RL = 8, M = 2, NMAX = 1024;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [AW:0]   vec_len;
  logic          busy, done, ram1_en_b, ram2_en_a, ram2_wr_en_a, acc_clr, acc_en;
  logic          reci_start, ram2_en_b, ram3_enable_a, ram3_wr_en_a;
  logic [AW-1:0] ram1_addr, ram2_addr_a, ram2_addr_b, ram3_addr_a;
  logic [2:0]    phase;

  always #5 clk = ~clk;

  softmax_sequencer #(.ADDR_W(AW), .EXP_LAT(E), .ACC_LAT(A), .RECI_LAT(RL), .MUL_LAT(M)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .busy(busy), .done(done),
    .ram1_en_b(ram1_en_b), .ram1_addr(ram1_addr), .ram2_en_a(ram2_en_a),
    .ram2_wr_en_a(ram2_wr_en_a), .ram2_addr_a(ram2_addr_a), .acc_clr(acc_clr),
    .acc_en(acc_en), .reci_start(reci_start), .ram2_en_b(ram2_en_b),
    .ram2_addr_b(ram2_addr_b), .ram3_enable_a(ram3_enable_a), .ram3_wr_en_a(ram3_wr_en_a),
    .ram3_addr_a(ram3_addr_a), .phase(phase)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Reference model: one accepted run of n elements, timed from its start cycle.
  int cyc = 0;
  bit m_active = 0;
  int m_t0 = 0, m_n = 0;

  function automatic int done_at(input int n);
    return n + E + A + 1 + RL + M + n;
  endfunction

  function automatic logic [63:0] exp_vec(input int k, input int n);
    int r, b0, w0, d;
    logic bz, dn, r1, w2, clr, rc, r2b, w3;
    logic [AW-1:0] r1a, w2a, r2ba, w3a;
    r   = n + E + A + 1;       // reciprocal launch
    b0  = r + RL;              // first ram2 port-b read
    w0  = b0 + M;              // first ram3 write
    d   = w0 + n;              // done pulse
    bz  = (k < d);
    dn  = (k == d);
    clr = (k == 0);
    rc  = (k == r);
    r1  = (k >= 1) && (k <= n);
    w2  = (k >= E + 1) && (k <= E + n);
    r2b = (k >= b0) && (k < b0 + n);
    w3  = (k >= w0) && (k < w0 + n);
    r1a  = r1  ? AW'(k - 1)     : '0;
    w2a  = w2  ? AW'(k - E - 1) : '0;
    r2ba = r2b ? AW'(k - b0)    : '0;
    w3a  = w3  ? AW'(k - w0)    : '0;
    return {12'b0, bz, dn, r1, r1a, w2, w2, w2a, clr, w2, rc, r2b, r2ba, w3, w3, w3a, !bz};
  endfunction

  int st_done, st_done_cyc, st_ram3, st_last3, st_clr, st_wr2;
  bit wr2_seen [NMAX];

  task automatic clear_stats();
    st_done = 0; st_done_cyc = -1; st_ram3 = 0; st_last3 = -1; st_clr = 0; st_wr2 = 0;
    for (int i = 0; i < NMAX; i++) wr2_seen[i] = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic st, input int vl, input logic rs);
    logic [63:0] act, expv;
    @(negedge clk);
    start = st; vec_len = (AW+1)'(vl); rst = rs;
    @(posedge clk);
    cyc++;
    if (!rs) m_active = 0;
    else if (st && vl != 0 && (!m_active || cyc > m_t0 + done_at(m_n))) begin
      m_active = 1; m_t0 = cyc; m_n = (vl > NMAX) ? NMAX : vl;
    end
    #1;
    act = {12'b0, busy, done, ram1_en_b, ram1_addr, ram2_en_a, ram2_wr_en_a, ram2_addr_a,
           acc_clr, acc_en, reci_start, ram2_en_b, ram2_addr_b, ram3_enable_a,
           ram3_wr_en_a, ram3_addr_a, (phase == 3'(S_IDLE))};
    expv = m_active ? exp_vec(cyc - m_t0, m_n) : 64'h1;
    check_eq($sformatf("c%0d", cyc), act, expv);
    if (done) begin st_done++; st_done_cyc = cyc; end
    if (ram3_wr_en_a) begin st_ram3++; st_last3 = int'(ram3_addr_a); end
    if (acc_clr) st_clr++;
    if (ram2_wr_en_a) begin st_wr2++; wr2_seen[ram2_addr_a] = 1'b1; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
  endtask

  int t;

  initial begin
    rst = 1'b0; start = 1'b0; vec_len = '0;
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0);
    idle(2);

    // N=5 reference run
    clear_stats();
    step(1'b1, 5, 1'b1); t = cyc;
    idle(34);
    check_eq("n5_done_cnt", st_done, 1);
    check_eq("n5_done_cyc", st_done_cyc - t, 28);
    check_eq("n5_ram3_cnt", st_ram3, 5);
    check_eq("n5_ram3_last", st_last3, 4);
    check_eq("n5_clr_cnt", st_clr, 1);

    // zero-length request is ignored
    clear_stats();
    step(1'b1, 0, 1'b1);
    idle(6);
    check_eq("zero_done", st_done, 0);
    check_eq("zero_clr", st_clr, 0);
    check_eq("zero_wr2", st_wr2, 0);

    // second start in cycle 10 is ignored
    clear_stats();
    step(1'b1, 5, 1'b1); t = cyc;
    idle(9);
    step(1'b1, 1 + $urandom_range(0, 20), 1'b1);
    idle(24);
    check_eq("busy_start_done", st_done, 1);
    check_eq("busy_start_cyc", st_done_cyc - t, 28);
    check_eq("busy_start_clr", st_clr, 1);

    // reset in the middle of the exponent phase
    clear_stats();
    step(1'b1, 5, 1'b1);
    idle(7);
    step(1'b0, 0, 1'b0);
    idle(30);
    check_eq("rst_wr2_cnt", st_wr2, 3);
    check_eq("rst_no_addr3", wr2_seen[3], 0);
    check_eq("rst_no_addr4", wr2_seen[4], 0);
    check_eq("rst_no_done", st_done, 0);

    // full-depth vector
    clear_stats();
    step(1'b1, NMAX, 1'b1);
    idle(done_at(NMAX) + 3);
    check_eq("full_ram3_cnt", st_ram3, NMAX);
    check_eq("full_ram3_last", st_last3, NMAX - 1);
    check_eq("full_done", st_done, 1);

    // back-to-back N=3 then N=2, second start right after done
    clear_stats();
    step(1'b1, 3, 1'b1);
    idle(done_at(3));
    step(1'b1, 2, 1'b1);
    idle(done_at(2) + 3);
    check_eq("b2b_done", st_done, 2);
    check_eq("b2b_clr", st_clr, 2);
    check_eq("b2b_ram3", st_ram3, 5);

    // oversize request is clamped to the RAM depth
    clear_stats();
    step(1'b1, $urandom_range(NMAX + 1, 2047), 1'b1);
    idle(done_at(NMAX) + 2);
    check_eq("clamp_ram3_cnt", st_ram3, NMAX);
    check_eq("clamp_done", st_done, 1);

    // random starts, lengths and occasional resets
    for (int i = 0; i < 800; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b0, $urandom_range(0, 12), 1'b0);
      else if (r < 25) step(1'b1, $urandom_range(0, 12), 1'b1);
      else             step(1'b0, $urandom_range(0, 2047), 1'b1);
    end
    idle(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
